// File: rtl/regfile_write_sequencer.sv
// regfile_write_sequencer
//   Write-side front end for the register file's single write port. Results
//   from the writeback pipeline (wb) and the long-latency unit (lu) are
//   serialised through an in-order pending queue. RegWrite/WriteRegister/
//   WriteData are registered. Two lookup ports report registers whose
//   writes are still pending, so decode can stall on them.
//
// Ports
//   clk, reset            clock (rising edge), async active-low reset
//   wb_valid/reg/data     writeback result offer, wb_ready accept
//   lu_valid/reg/data     long-latency result offer, lu_ready accept
//   RegWrite, WriteRegister, WriteData   register-file write port
//   pend_query1/2         lookup indices, pend_hit1/2 pending flags
//   queue_count           occupied queue entries
//
// Optional build macro REGSEQ_FORWARD_EN adds pend_data1/2: the youngest
// pending value for each lookup index (0 when there is no hit).
module regfile_write_sequencer #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 4,
  parameter int ZERO_REG = 31
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wb_valid,
  input  logic [ADDR_W-1:0]          wb_reg,
  input  logic [DATA_W-1:0]          wb_data,
  output logic                       wb_ready,
  input  logic                       lu_valid,
  input  logic [ADDR_W-1:0]          lu_reg,
  input  logic [DATA_W-1:0]          lu_data,
  output logic                       lu_ready,
  output logic                       RegWrite,
  output logic [ADDR_W-1:0]          WriteRegister,
  output logic [DATA_W-1:0]          WriteData,
  input  logic [ADDR_W-1:0]          pend_query1,
  input  logic [ADDR_W-1:0]          pend_query2,
  output logic                       pend_hit1,
  output logic                       pend_hit2,
`ifdef REGSEQ_FORWARD_EN
  output logic [DATA_W-1:0]          pend_data1,
  output logic [DATA_W-1:0]          pend_data2,
`endif
  output logic [$clog2(DEPTH+1)-1:0] queue_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ZERO_C  = ADDR_W'(ZERO_REG);

  logic [ADDR_W-1:0] q_reg_q  [DEPTH];
  logic [DATA_W-1:0] q_data_q [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_ptr_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              wb_take, wb_en, lu_en;
  logic              pop, push_a, push_b;
  logic [ADDR_W-1:0] push_a_reg;
  logic [DATA_W-1:0] push_a_data;

  // Ready looks only at registered state (plus wb_valid for lu), so no credit
  // is given for the entry drained at the same edge.
  assign wb_ready = reset & (cnt_q < DEPTH_C);
  assign wb_take  = wb_valid & wb_ready;
  assign lu_ready = reset & ((cnt_q + CNT_W'(wb_take)) < DEPTH_C);

  // Writes to the zero register complete the handshake but go nowhere.
  assign wb_en = wb_take & (wb_reg != ZERO_C);
  assign lu_en = lu_valid & lu_ready & (lu_reg != ZERO_C);

  // Candidate order: queue head, then wb, then lu. First one goes to the
  // output register, the rest append to the tail in the same order.
  always_comb begin
    pop         = 1'b0;
    push_a      = 1'b0;
    push_b      = 1'b0;
    push_a_reg  = lu_reg;
    push_a_data = lu_data;
    we_d        = 1'b0;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    if (cnt_q != '0) begin
      pop     = 1'b1;
      we_d    = 1'b1;
      wreg_d  = q_reg_q[rd_ptr_q];
      wdata_d = q_data_q[rd_ptr_q];
      push_a  = wb_en | lu_en;
      push_b  = wb_en & lu_en;
      if (wb_en) begin
        push_a_reg  = wb_reg;
        push_a_data = wb_data;
      end
    end else if (wb_en) begin
      we_d    = 1'b1;
      wreg_d  = wb_reg;
      wdata_d = wb_data;
      push_a  = lu_en;
    end else if (lu_en) begin
      we_d    = 1'b1;
      wreg_d  = lu_reg;
      wdata_d = lu_data;
    end
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_a) + PTR_W'(push_b);
    cnt_d    = cnt_q - CNT_W'(pop) + CNT_W'(push_a) + CNT_W'(push_b);
  end

  assign wr_ptr_nxt = wr_ptr_q + PTR_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
    end
  end

  // Payload storage needs no reset: validity is carried by cnt_q.
  always_ff @(posedge clk) begin
    if (push_a) begin
      q_reg_q[wr_ptr_q]  <= push_a_reg;
      q_data_q[wr_ptr_q] <= push_a_data;
    end
    if (push_b) begin
      q_reg_q[wr_ptr_nxt]  <= lu_reg;
      q_data_q[wr_ptr_nxt] <= lu_data;
    end
  end

  // Lookup: the output register holds the oldest pending write, queue
  // entries get younger with offset k, so later matches override earlier.
  always_comb begin
    pend_hit1 = we_q & (wreg_q == pend_query1);
    pend_hit2 = we_q & (wreg_q == pend_query2);
`ifdef REGSEQ_FORWARD_EN
    pend_data1 = pend_hit1 ? wdata_q : '0;
    pend_data2 = pend_hit2 ? wdata_q : '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < cnt_q) begin
        if (q_reg_q[rd_ptr_q + PTR_W'(k)] == pend_query1) begin
          pend_hit1 = 1'b1;
`ifdef REGSEQ_FORWARD_EN
          pend_data1 = q_data_q[rd_ptr_q + PTR_W'(k)];
`endif
        end
        if (q_reg_q[rd_ptr_q + PTR_W'(k)] == pend_query2) begin
          pend_hit2 = 1'b1;
`ifdef REGSEQ_FORWARD_EN
          pend_data2 = q_data_q[rd_ptr_q + PTR_W'(k)];
`endif
        end
      end
    end
    if (pend_query1 == ZERO_C) begin
      pend_hit1 = 1'b0;
`ifdef REGSEQ_FORWARD_EN
      pend_data1 = '0;
`endif
    end
    if (pend_query2 == ZERO_C) begin
      pend_hit2 = 1'b0;
`ifdef REGSEQ_FORWARD_EN
      pend_data2 = '0;
`endif
    end
  end

  assign RegWrite      = we_q;
  assign WriteRegister = wreg_q;
  assign WriteData     = wdata_q;
  assign queue_count   = cnt_q;

endmodule
